// File: rtl/score_pkg.sv
// Shared definitions for the score bookkeeping stage and the score display driver.
package score_pkg;

  localparam int SCORE_W           = 7;
  localparam int DEFAULT_MAX_SCORE = 99;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_t;

  // Add an increment (0..16) to a score, clamping at max_score instead of wrapping.
  // The sum is formed one bit wider than the score so 99 + 16 cannot overflow.
  function automatic logic [SCORE_W-1:0] sat_add(
    input logic [SCORE_W-1:0] score,
    input logic [4:0]         inc,
    input logic [SCORE_W-1:0] max_score
  );
    logic [SCORE_W:0] sum;
    sum = {1'b0, score} + {3'b000, inc};
    if (sum > {1'b0, max_score}) begin
      return max_score;
    end
    return sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/score_keeper_phase_timer.sv
// Free-running phase timer for the game-over display swap. Counts
// 0..SWAP_CYCLES-1 while enabled and flags the terminal count with o_Tick,
// the cycle whose following edge toggles the display phase. Held at 0 while
// disabled or cleared so every game-over entry starts a fresh phase.
module phase_timer #(
  parameter int SWAP_CYCLES = 25_000_000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Enable,
  input  logic i_Clear,
  output logic o_Tick
);

  localparam int TW = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(SWAP_CYCLES - 1);

  logic [TW-1:0] count;

  assign o_Tick = i_Enable && !i_Clear && (count == LAST);

  // Count while enabled, wrap at terminal count, otherwise hold at zero.
  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clear || !i_Enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Game score bookkeeping: accumulates points with saturation, keeps the best
// score across games and, after game over, alternates the displayed value
// between the last score (phase A) and the best score (phase B).
// Inputs are single-cycle pulses sampled on each rising edge; there is no
// handshake, a held level simply counts once per cycle. Every output is
// registered, so an event sampled at edge N shows up right after edge N.
module score_keeper
  import score_pkg::*;
#(
  parameter int MAX_SCORE   = DEFAULT_MAX_SCORE,
  parameter int SWAP_CYCLES = 25_000_000
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Start,
  input  logic                i_Point,
  input  logic                i_Add_Valid,
  input  logic [3:0]          i_Add_Amount,
  input  logic                i_Game_Over,
  output logic [SCORE_W-1:0]  o_Score,
  output logic                o_Showing_Best,
  output logic                o_Playing,
  output logic                o_New_Best,
  output logic [1:0]          o_State
);

  localparam logic [SCORE_W-1:0] MAX_VAL = SCORE_W'(MAX_SCORE);

  state_t             state, state_n;
  logic [SCORE_W-1:0] score, score_n;
  logic [SCORE_W-1:0] best, best_n;
  logic               phase, phase_n;        // 0: last score, 1: best score
  logic               new_best_n;
  logic               show_best_n;
  logic [SCORE_W-1:0] score_out_n;
  logic [4:0]         inc;
  logic [SCORE_W-1:0] sum_score;
  logic               tick;

  assign o_State = state;

  phase_timer #(
    .SWAP_CYCLES(SWAP_CYCLES)
  ) u_phase_timer (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Enable (state == ST_GAME_OVER),
    .i_Clear  (i_Start),
    .o_Tick   (tick)
  );

  // Next-state, score/best update and next registered output values.
  always_comb begin
    state_n     = state;
    score_n     = score;
    best_n      = best;
    phase_n     = phase;
    new_best_n  = 1'b0;
    inc         = {4'b0000, i_Point} + (i_Add_Valid ? {1'b0, i_Add_Amount} : 5'd0);
    sum_score   = sat_add(score, inc, MAX_VAL);
    case (state)
      ST_IDLE: begin
        if (i_Start) begin
          state_n = ST_PLAYING;
          score_n = '0;
        end
      end
      ST_PLAYING: begin
        // Start wins over both the increment and game over.
        if (i_Start) begin
          score_n = '0;
        end else begin
          score_n = sum_score;
          if (i_Game_Over) begin
            state_n = ST_GAME_OVER;
            phase_n = 1'b0;
            if (sum_score > best) begin
              best_n     = sum_score;
              new_best_n = 1'b1;
            end
          end
        end
      end
      ST_GAME_OVER: begin
        if (i_Start) begin
          state_n = ST_PLAYING;
          score_n = '0;
          phase_n = 1'b0;
        end else if (tick) begin
          phase_n = ~phase;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    show_best_n = (state_n == ST_IDLE) || ((state_n == ST_GAME_OVER) && phase_n);
    score_out_n = show_best_n ? best_n : score_n;
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state          <= ST_IDLE;
      score          <= '0;
      best           <= '0;
      phase          <= 1'b0;
      o_Score        <= '0;
      o_Showing_Best <= 1'b1;
      o_Playing      <= 1'b0;
      o_New_Best     <= 1'b0;
    end else begin
      state          <= state_n;
      score          <= score_n;
      best           <= best_n;
      phase          <= phase_n;
      o_Score        <= score_out_n;
      o_Showing_Best <= show_best_n;
      o_Playing      <= (state_n == ST_PLAYING);
      o_New_Best     <= new_best_n;
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper with a short swap period. A behavioural model tracks
// mode, score, best and cycles spent in game over; directed scenarios and a
// randomized run compare DUT outputs against it after every clock edge.
module tb_score_keeper;

  localparam int SWAP = 4;
  localparam int MAXS = 99;

  logic       clk;
  logic       rst;
  logic       start;
  logic       point;
  logic       add_valid;
  logic [3:0] add_amount;
  logic       game_over;
  logic [6:0] score;
  logic       showing_best;
  logic       playing;
  logic       new_best;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = idle, 1 = playing, 2 = game over.
  int m_mode, m_score, m_best, m_cnt, m_nb;
  int e_score, e_show, e_play, e_nb;

  score_keeper #(
    .MAX_SCORE   (MAXS),
    .SWAP_CYCLES (SWAP)
  ) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Start        (start),
    .i_Point        (point),
    .i_Add_Valid    (add_valid),
    .i_Add_Amount   (add_amount),
    .i_Game_Over    (game_over),
    .o_Score        (score),
    .o_Showing_Best (showing_best),
    .o_Playing      (playing),
    .o_New_Best     (new_best),
    .o_State        (state_dbg)
  );

  // Clock and initial input levels.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b0; start = 1'b0; point = 1'b0; add_valid = 1'b0;
    add_amount = 4'd0; game_over = 1'b0;
    m_mode = 0; m_score = 0; m_best = 0; m_cnt = 0; m_nb = 0;
    e_score = 0; e_show = 1; e_play = 0; e_nb = 0;
  end

  // Apply one cycle of inputs, advance the model on the same edge, settle.
  task automatic step(input logic r, input logic s, input logic p,
                      input logic av, input logic [3:0] amt, input logic g);
    int inc;
    @(negedge clk);
    rst = r; start = s; point = p; add_valid = av; add_amount = amt; game_over = g;
    @(posedge clk);
    m_nb = 0;
    if (r) begin
      m_mode = 0; m_score = 0; m_best = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (s) begin m_mode = 1; m_score = 0; end
    end else if (m_mode == 1) begin
      if (s) begin
        m_score = 0;
      end else begin
        inc = int'(p) + (av ? int'(amt) : 0);
        m_score = (m_score + inc > MAXS) ? MAXS : m_score + inc;
        if (g) begin
          m_mode = 2; m_cnt = 0;
          if (m_score > m_best) begin m_best = m_score; m_nb = 1; end
        end
      end
    end else begin
      if (s) begin m_mode = 1; m_score = 0; end
      else m_cnt++;
    end
    e_show  = (m_mode == 0) || (m_mode == 2 && ((m_cnt / SWAP) % 2) == 1);
    e_score = e_show ? m_best : m_score;
    e_play  = (m_mode == 1);
    e_nb    = m_nb;
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    checks++;
    if (score !== 7'd0 || showing_best !== 1'b1 || playing !== 1'b0 || new_best !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: score=%0d show=%0b play=%0b nb=%0b required 0/1/0/0",
               score, showing_best, playing, new_best);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0);
      checks++;
      if (score !== 7'd0 || playing !== 1'b0) begin
        errors++;
        $display("FAIL idle_ignores_points: score=%0d play=%0b required 0/0", score, playing);
      end
    end
  endtask

  task automatic test_basic_game();
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    checks++;
    if (playing !== 1'b1 || score !== 7'd0 || showing_best !== 1'b0) begin
      errors++;
      $display("FAIL start_playing: play=%0b score=%0d show=%0b required 1/0/0",
               playing, score, showing_best);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
    checks++;
    if (score !== 7'd8 || score !== e_score[6:0]) begin
      errors++;
      $display("FAIL basic_score: got %0d required 8 (model %0d)", score, e_score);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    checks++;
    if (new_best !== 1'b1 || score !== 7'd8 || playing !== 1'b0 || showing_best !== 1'b0) begin
      errors++;
      $display("FAIL basic_game_over: nb=%0b score=%0d play=%0b show=%0b required 1/8/0/0",
               new_best, score, playing, showing_best);
    end
    idle_step();
    checks++;
    if (new_best !== 1'b0) begin
      errors++;
      $display("FAIL new_best_one_cycle: got %0b required 0", new_best);
    end
  endtask

  task automatic test_swap();
    int want;
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) idle_step();
      want = ((i / SWAP) % 2 == 1) ? 8 : 3;
      checks++;
      if (score !== want[6:0] || showing_best !== ((i / SWAP) % 2 == 1) ||
          score !== e_score[6:0] || new_best !== 1'b0) begin
        errors++;
        $display("FAIL swap_cycle_%0d: score=%0d show=%0b nb=%0b required %0d/%0b/0",
                 i, score, showing_best, new_best, want, (i / SWAP) % 2);
      end
    end
  endtask

  task automatic test_simultaneous();
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    checks++;
    if (score !== 7'd0 || playing !== 1'b1) begin
      errors++;
      $display("FAIL start_beats_point: score=%0d play=%0b required 0/1", score, playing);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    checks++;
    if (playing !== 1'b1 || new_best !== 1'b0 || score !== 7'd0) begin
      errors++;
      $display("FAIL start_beats_game_over: play=%0b nb=%0b score=%0d required 1/0/0",
               playing, new_best, score);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    checks++;
    if (new_best !== 1'b1 || score !== 7'd9 || playing !== 1'b0) begin
      errors++;
      $display("FAIL game_over_with_point: nb=%0b score=%0d play=%0b required 1/9/0",
               new_best, score, playing);
    end
    for (int i = 0; i < SWAP; i++) idle_step();
    checks++;
    if (showing_best !== 1'b1 || score !== 7'd9) begin
      errors++;
      $display("FAIL phase_b_best: show=%0b score=%0d required 1/9", showing_best, score);
    end
  endtask

  task automatic test_reset_mid_phase();
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    checks++;
    if (score !== 7'd0 || showing_best !== 1'b1 || playing !== 1'b0 || new_best !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_phase: score=%0d show=%0b play=%0b nb=%0b required 0/1/0/0",
               score, showing_best, playing, new_best);
    end
  endtask

  task automatic test_saturation();
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
    checks++;
    if (score !== 7'd95) begin
      errors++;
      $display("FAIL sat_reach_95: got %0d required 95", score);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
    checks++;
    if (score !== 7'd99) begin
      errors++;
      $display("FAIL sat_clamp: got %0d required 99", score);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
      checks++;
      if (score !== 7'd99) begin
        errors++;
        $display("FAIL sat_hold_%0d: got %0d required 99", i, score);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    checks++;
    if (new_best !== 1'b1 || score !== 7'd99) begin
      errors++;
      $display("FAIL sat_game_over: nb=%0b score=%0d required 1/99", new_best, score);
    end
  endtask

  task automatic test_random();
    logic r, s, p, av, g;
    logic [3:0] amt;
    for (int i = 0; i < 800; i++) begin
      r   = ($urandom_range(0, 149) == 0);
      s   = ($urandom_range(0, 24) == 0);
      g   = ($urandom_range(0, 11) == 0);
      p   = 1'($urandom_range(0, 1));
      av  = ($urandom_range(0, 2) == 0);
      amt = 4'($urandom_range(0, 15));
      step(r, s, p, av, amt, g);
      checks++;
      if (score !== e_score[6:0] || showing_best !== e_show[0] ||
          playing !== e_play[0] || new_best !== e_nb[0]) begin
        errors++;
        $display("FAIL random_%0d: score=%0d show=%0b play=%0b nb=%0b required %0d/%0b/%0b/%0b",
                 i, score, showing_best, playing, new_best, e_score, e_show[0], e_play[0], e_nb[0]);
      end
    end
  endtask

  // Scenario sequence and final report.
  initial begin
    #2;
    test_reset();
    test_basic_game();
    test_swap();
    test_simultaneous();
    test_reset_mid_phase();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
